// File: rtl/store_pkg.sv
// Shared definitions for the store alignment buffer: access-size encodings
// and a helper that turns a size code into a contiguous byte-lane mask.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } st_size_e;

  // Contiguous low-order ones, one per byte of the access size.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      SZ_D:    mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_align_buffer_if.sv
// Bundle of the store-request, memory-write and load-hazard signals of the
// store alignment buffer. The buffer uses the slave view; the memory stage,
// data memory and load path together form the master view.
interface store_align_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  st_valid;
  logic [1:0]            st_size;
  logic [ADDR_W-1:0]     st_addr;
  logic [DATA_W-1:0]     st_data;
  logic                  st_ready;
  logic                  st_ades;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ack;
  logic [ADDR_W-1:0]     ld_addr;
  logic                  ld_hit;
  logic                  empty;

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_ack, ld_addr,
    input  st_ready, st_ades, mem_req, mem_addr, mem_wdata, mem_wstrb,
           ld_hit, empty
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_ack, ld_addr,
    output st_ready, st_ades, mem_req, mem_addr, mem_wdata, mem_wstrb,
           ld_hit, empty
  );

endinterface

// File: rtl/store_fmt.sv
// Combinational store formatter: replicates the LSB-aligned store data across
// the memory word, builds the byte strobes and flags misaligned accesses.
module store_fmt
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic [2:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                misalign_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [7:0]       full_mask_s;
  logic [BYTES-1:0] mask_s;

  // Replicate the active low-order slice of the data across every lane
  always_comb begin
    wdata_o = {DATA_W{1'b0}};
    case (size_i)
      SZ_B: for (int i = 0; i < BYTES; i++)       wdata_o[8*i +: 8]   = data_i[7:0];
      SZ_H: for (int i = 0; i < DATA_W / 16; i++) wdata_o[16*i +: 16] = data_i[15:0];
      SZ_W: for (int i = 0; i < DATA_W / 32; i++) wdata_o[32*i +: 32] = data_i[31:0];
      SZ_D:    wdata_o = data_i;
      default: wdata_o = data_i;
    endcase
  end

  // Byte strobes: one bit per accessed byte, shifted to the lane offset
  always_comb begin
    full_mask_s = size_mask(size_i);
    mask_s      = full_mask_s[BYTES-1:0];
    wstrb_o     = mask_s << addr_lo_i[OFF_W-1:0];
  end

  // An access is misaligned when its offset is not a multiple of its size;
  // a dword can never be aligned on a 32-bit memory
  always_comb begin
    misalign_o = 1'b0;
    case (size_i)
      SZ_B:    misalign_o = 1'b0;
      SZ_H:    misalign_o = addr_lo_i[0];
      SZ_W:    misalign_o = (addr_lo_i[1:0] != 2'd0);
      SZ_D:    misalign_o = (DATA_W == 32) || (addr_lo_i != 3'd0);
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment buffer: formats accepted stores at enqueue, holds them in a
// DEPTH-entry FIFO and presents the head entry to data memory. Misaligned
// stores are dropped and reported with a one-cycle error flag. A load hazard
// check compares a younger load's beat address against all buffered stores.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input logic                 clk,
  input logic                 resetn,
  store_align_buffer_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_FULL   = DEPTH[CNT_W-1:0];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ades_q, ades_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BYTES-1:0]  strb_q [DEPTH];

  logic [DATA_W-1:0] fmt_wdata_s;
  logic [BYTES-1:0]  fmt_wstrb_s;
  logic              fmt_misalign_s;
  logic              empty_s;
  logic              full_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] st_aligned_s;
  logic [ADDR_W-1:0] ld_aligned_s;
  logic              ld_hit_s;

  store_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size_i     (bus.st_size),
    .addr_lo_i  (bus.st_addr[2:0]),
    .data_i     (bus.st_data),
    .wdata_o    (fmt_wdata_s),
    .wstrb_o    (fmt_wstrb_s),
    .misalign_o (fmt_misalign_s)
  );

  // Handshake decode: acceptance depends only on fullness, so a pop in the
  // full cycle frees a slot for the following cycle, not this one
  always_comb begin
    empty_s      = (count_q == {CNT_W{1'b0}});
    full_s       = (count_q == CNT_FULL);
    accept_s     = bus.st_valid && !full_s;
    push_s       = accept_s && !fmt_misalign_s;
    pop_s        = !empty_s && bus.mem_ack;
    st_aligned_s = bus.st_addr & ALIGN_MASK;
    ld_aligned_s = bus.ld_addr & ALIGN_MASK;
  end

  // Next-state for pointers, occupancy, per-entry valid bits and error flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    ades_d  = accept_s && fmt_misalign_s;
    if (push_s) begin
      tail_d          = tail_q + PTR_ONE;
      valid_d[tail_q] = 1'b1;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d          = head_q + PTR_ONE;
      valid_d[head_q] = 1'b0;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      valid_q <= {DEPTH{1'b0}};
      ades_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ades_q  <= ades_d;
    end
  end

  // Entry storage: the formatted store is written at the tail on push
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
        strb_q[i] <= {BYTES{1'b0}};
      end
    end else if (push_s) begin
      addr_q[tail_q] <= st_aligned_s;
      data_q[tail_q] <= fmt_wdata_s;
      strb_q[tail_q] <= fmt_wstrb_s;
    end
  end

  // Load hazard: any valid entry sharing the load's aligned beat
  always_comb begin
    ld_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit_s = ld_hit_s | (valid_q[i] && (addr_q[i] == ld_aligned_s));
    end
  end

  // Head entry drives memory; outputs are forced to zero while empty
  assign bus.st_ready  = !full_s;
  assign bus.st_ades   = ades_q;
  assign bus.mem_req   = !empty_s;
  assign bus.mem_addr  = empty_s ? {ADDR_W{1'b0}} : addr_q[head_q];
  assign bus.mem_wdata = empty_s ? {DATA_W{1'b0}} : data_q[head_q];
  assign bus.mem_wstrb = empty_s ? {BYTES{1'b0}}  : strb_q[head_q];
  assign bus.ld_hit    = ld_hit_s;
  assign bus.empty     = empty_s;

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed self-checking bench for store_align_buffer: a 32-bit and a 64-bit
// instance, each driven through its own interface instance.
module tb_store_align_buffer;
  import store_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  store_align_buffer_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  store_align_buffer_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  store_align_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .resetn(resetn), .bus(b32));
  store_align_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .resetn(resetn), .bus(b64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b32.st_valid = 1'b0; b32.st_size = 2'd0; b32.st_addr = 32'h0; b32.st_data = 32'h0;
    b32.mem_ack  = 1'b0; b32.ld_addr = 32'h0;
    b64.st_valid = 1'b0; b64.st_size = 2'd0; b64.st_addr = 32'h0; b64.st_data = 64'h0;
    b64.mem_ack  = 1'b0; b64.ld_addr = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #2;
    tests_run++; if (b32.st_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready32: got %b expected 1", b32.st_ready); end
    tests_run++; if (b32.st_ades !== 1'b0) begin tests_failed++; $display("FAIL rst_ades32: got %b expected 0", b32.st_ades); end
    tests_run++; if (b32.mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req32: got %b expected 0", b32.mem_req); end
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL rst_empty32: got %b expected 1", b32.empty); end
    tests_run++; if (b32.ld_hit !== 1'b0) begin tests_failed++; $display("FAIL rst_ldhit32: got %b expected 0", b32.ld_hit); end
    tests_run++; if (b32.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_wdata32: got %h expected 0", b32.mem_wdata); end
    tests_run++; if (b64.mem_wstrb !== 8'h00) begin tests_failed++; $display("FAIL rst_wstrb64: got %h expected 00", b64.mem_wstrb); end
    tests_run++; if (b64.empty !== 1'b1) begin tests_failed++; $display("FAIL rst_empty64: got %b expected 1", b64.empty); end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_format32();
    // ack while empty must be ignored
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL ack_empty32: got %b expected 1", b32.empty); end
    b32.st_valid = 1'b1; b32.st_size = SZ_B; b32.st_addr = 32'h0000_1003; b32.st_data = 32'h0000_00AB;
    tests_run++; if (b32.st_ready !== 1'b1) begin tests_failed++; $display("FAIL byte32_ready: got %b expected 1", b32.st_ready); end
    tests_run++; if (b32.mem_req !== 1'b0) begin tests_failed++; $display("FAIL byte32_nocomb: got %b expected 0", b32.mem_req); end
    tick();
    b32.st_valid = 1'b0;
    tests_run++; if (b32.mem_req !== 1'b1) begin tests_failed++; $display("FAIL byte32_req: got %b expected 1", b32.mem_req); end
    tests_run++; if (b32.mem_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL byte32_addr: got %h expected 00001000", b32.mem_addr); end
    tests_run++; if (b32.mem_wdata !== 32'hABAB_ABAB) begin tests_failed++; $display("FAIL byte32_data: got %h expected abababab", b32.mem_wdata); end
    tests_run++; if (b32.mem_wstrb !== 4'b1000) begin tests_failed++; $display("FAIL byte32_strb: got %b expected 1000", b32.mem_wstrb); end
    tick();
    tests_run++; if (b32.mem_wdata !== 32'hABAB_ABAB) begin tests_failed++; $display("FAIL byte32_hold: got %h expected abababab", b32.mem_wdata); end
    tests_run++; if (b32.mem_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL byte32_hold_addr: got %h expected 00001000", b32.mem_addr); end
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL byte32_pop: got %b expected 1", b32.empty); end
    tests_run++; if (b32.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL byte32_zero: got %h expected 0", b32.mem_wdata); end
    b32.st_valid = 1'b1; b32.st_size = SZ_H; b32.st_addr = 32'h0000_1002; b32.st_data = 32'hFFFF_5678;
    tick();
    b32.st_valid = 1'b0;
    tests_run++; if (b32.mem_wdata !== 32'h5678_5678) begin tests_failed++; $display("FAIL half32_data: got %h expected 56785678", b32.mem_wdata); end
    tests_run++; if (b32.mem_wstrb !== 4'b1100) begin tests_failed++; $display("FAIL half32_strb: got %b expected 1100", b32.mem_wstrb); end
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
  endtask

  task automatic test_format64();
    logic [1:0]  sz  [4] = '{SZ_H, SZ_W, SZ_D, SZ_B};
    logic [31:0] ad  [4] = '{32'h2006, 32'h2004, 32'h2008, 32'h2001};
    logic [63:0] dat [4] = '{64'h1234, 64'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 64'h5A};
    logic [31:0] ea  [4] = '{32'h2000, 32'h2000, 32'h2008, 32'h2000};
    logic [63:0] ed  [4] = '{64'h1234_1234_1234_1234, 64'hDEAD_BEEF_DEAD_BEEF,
                             64'h0123_4567_89AB_CDEF, 64'h5A5A_5A5A_5A5A_5A5A};
    logic [7:0]  es  [4] = '{8'hC0, 8'hF0, 8'hFF, 8'h02};
    for (int i = 0; i < 4; i++) begin
      b64.st_valid = 1'b1; b64.st_size = sz[i]; b64.st_addr = ad[i]; b64.st_data = dat[i];
      tick();
    end
    b64.st_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (b64.mem_addr !== ea[i]) begin tests_failed++; $display("FAIL fmt64_addr[%0d]: got %h expected %h", i, b64.mem_addr, ea[i]); end
      tests_run++; if (b64.mem_wdata !== ed[i]) begin tests_failed++; $display("FAIL fmt64_data[%0d]: got %h expected %h", i, b64.mem_wdata, ed[i]); end
      tests_run++; if (b64.mem_wstrb !== es[i]) begin tests_failed++; $display("FAIL fmt64_strb[%0d]: got %h expected %h", i, b64.mem_wstrb, es[i]); end
      b64.mem_ack = 1'b1;
      tick();
      b64.mem_ack = 1'b0;
    end
    tests_run++; if (b64.empty !== 1'b1) begin tests_failed++; $display("FAIL fmt64_empty: got %b expected 1", b64.empty); end
  endtask

  task automatic test_misalign();
    logic [1:0]  sz [3] = '{SZ_W, SZ_H, SZ_D};
    logic [31:0] ad [3] = '{32'h1002, 32'h1001, 32'h1000};
    for (int i = 0; i < 3; i++) begin
      b32.st_valid = 1'b1; b32.st_size = sz[i]; b32.st_addr = ad[i]; b32.st_data = 32'hCAFE_F00D;
      tick();
      b32.st_valid = 1'b0;
      tests_run++; if (b32.st_ades !== 1'b1) begin tests_failed++; $display("FAIL ades_hi[%0d]: got %b expected 1", i, b32.st_ades); end
      tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL ades_empty[%0d]: got %b expected 1", i, b32.empty); end
      tick();
      tests_run++; if (b32.st_ades !== 1'b0) begin tests_failed++; $display("FAIL ades_lo[%0d]: got %b expected 0", i, b32.st_ades); end
      tests_run++; if (b32.mem_req !== 1'b0) begin tests_failed++; $display("FAIL ades_req[%0d]: got %b expected 0", i, b32.mem_req); end
    end
  endtask

  task automatic test_full();
    logic [31:0] ea [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] ed [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    for (int i = 0; i < 4; i++) begin
      b32.st_valid = 1'b1; b32.st_size = SZ_W; b32.st_addr = ea[i]; b32.st_data = ed[i];
      tests_run++; if (b32.st_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready[%0d]: got %b expected 1", i, b32.st_ready); end
      tick();
    end
    b32.st_addr = 32'h110; b32.st_data = 32'h5555_5555;
    tests_run++; if (b32.st_ready !== 1'b0) begin tests_failed++; $display("FAIL full_notready: got %b expected 0", b32.st_ready); end
    tick();
    tests_run++; if (b32.st_ready !== 1'b0) begin tests_failed++; $display("FAIL full_refused: got %b expected 0", b32.st_ready); end
    b32.mem_ack = 1'b1;
    tests_run++; if (b32.st_ready !== 1'b0) begin tests_failed++; $display("FAIL full_nobypass: got %b expected 0", b32.st_ready); end
    tick();
    b32.st_valid = 1'b0;
    b32.mem_ack  = 1'b0;
    tests_run++; if (b32.st_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_after_pop: got %b expected 1", b32.st_ready); end
    for (int i = 1; i < 4; i++) begin
      tests_run++; if (b32.mem_addr !== ea[i]) begin tests_failed++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, b32.mem_addr, ea[i]); end
      tests_run++; if (b32.mem_wdata !== ed[i]) begin tests_failed++; $display("FAIL drain_data[%0d]: got %h expected %h", i, b32.mem_wdata, ed[i]); end
      b32.mem_ack = 1'b1;
      tick();
      b32.mem_ack = 1'b0;
    end
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty: got %b expected 1", b32.empty); end
  endtask

  task automatic test_back_to_back();
    b32.st_valid = 1'b1; b32.st_size = SZ_W; b32.st_addr = 32'h200; b32.st_data = 32'hAAAA_0001;
    tick();
    b32.st_addr = 32'h204; b32.st_data = 32'hBBBB_0002; b32.mem_ack = 1'b1;
    tick();
    b32.st_valid = 1'b0; b32.mem_ack = 1'b0;
    tests_run++; if (b32.mem_addr !== 32'h204) begin tests_failed++; $display("FAIL b2b_addr: got %h expected 00000204", b32.mem_addr); end
    tests_run++; if (b32.mem_wdata !== 32'hBBBB_0002) begin tests_failed++; $display("FAIL b2b_data: got %h expected bbbb0002", b32.mem_wdata); end
    tests_run++; if (b32.empty !== 1'b0) begin tests_failed++; $display("FAIL b2b_count: got %b expected 0", b32.empty); end
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty: got %b expected 1", b32.empty); end
  endtask

  task automatic test_ld_hit();
    b32.st_valid = 1'b1; b32.st_size = SZ_W; b32.st_addr = 32'h3004; b32.st_data = 32'h77;
    tick();
    b32.st_valid = 1'b0;
    b32.ld_addr = 32'h3006; #1;
    tests_run++; if (b32.ld_hit !== 1'b1) begin tests_failed++; $display("FAIL ldhit_3006: got %b expected 1", b32.ld_hit); end
    b32.ld_addr = 32'h3008; #1;
    tests_run++; if (b32.ld_hit !== 1'b0) begin tests_failed++; $display("FAIL ldhit_3008: got %b expected 0", b32.ld_hit); end
    b32.ld_addr = 32'h3004;
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tests_run++; if (b32.ld_hit !== 1'b0) begin tests_failed++; $display("FAIL ldhit_popped: got %b expected 0", b32.ld_hit); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      b32.st_valid = 1'b1; b32.st_size = SZ_W;
      b32.st_addr = 32'h400 + 32'(4 * i); b32.st_data = 32'h9000_0000 + 32'(i);
      tick();
    end
    b32.st_valid = 1'b0;
    b32.ld_addr  = 32'h404;
    tests_run++; if (b32.mem_req !== 1'b1) begin tests_failed++; $display("FAIL rmid_req_before: got %b expected 1", b32.mem_req); end
    resetn = 1'b0;
    #1;
    tests_run++; if (b32.mem_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_req: got %b expected 0", b32.mem_req); end
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL rmid_empty: got %b expected 1", b32.empty); end
    tests_run++; if (b32.mem_wstrb !== 4'b0000) begin tests_failed++; $display("FAIL rmid_strb: got %b expected 0000", b32.mem_wstrb); end
    tests_run++; if (b32.ld_hit !== 1'b0) begin tests_failed++; $display("FAIL rmid_ldhit: got %b expected 0", b32.ld_hit); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL rmid_stale: got %b expected 1", b32.empty); end
    b32.st_valid = 1'b1; b32.st_size = SZ_W; b32.st_addr = 32'h500; b32.st_data = 32'h55;
    tick();
    b32.st_valid = 1'b0;
    tests_run++; if (b32.mem_addr !== 32'h500) begin tests_failed++; $display("FAIL rmid_new_head: got %h expected 00000500", b32.mem_addr); end
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tests_run++; if (b32.empty !== 1'b1) begin tests_failed++; $display("FAIL rmid_final_empty: got %b expected 1", b32.empty); end
  endtask

  initial begin
    test_reset();
    test_format32();
    test_format64();
    test_misalign();
    test_full();
    test_back_to_back();
    test_ld_hit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter DEPTH, default 4, number of buffer entries; must be a power of two and at least 2.
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port st_valid  input  1  store request from the memory stage.
REQ-007 Port st_size  input  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64).
REQ-008 Port st_addr  input  ADDR_W  store byte address.
REQ-009 Port st_data  input  DATA_W  unformatted store data, LSB-aligned.
REQ-010 Port st_ready  output  1  buffer can accept a request this cycle.
REQ-011 Port st_ades  output  1  one-cycle misaligned-store error flag.
REQ-012 Port mem_req  output  1  head entry valid toward data memory.
REQ-013 Port mem_addr  output  ADDR_W  head address, aligned down to DATA_W/8 bytes.
REQ-014 Port mem_wdata  output  DATA_W  replicated store data.
REQ-015 Port mem_wstrb  output  DATA_W/8  byte strobes.
REQ-016 Port mem_ack  input  1  memory consumed the head entry.
REQ-017 Port ld_addr  input  ADDR_W  address of a younger load, used for the hazard check.
REQ-018 Port ld_hit  output  1  a buffered store overlaps the load's aligned beat.
REQ-019 Port empty  output  1  buffer holds no entries; used for drain and fence.

Function
REQ-020 Acceptance: a request is accepted when st_valid and st_ready are both high; st_ready is high exactly when the buffer is not full.
REQ-021 Alignment: a request is misaligned when st_addr modulo 2^st_size is non-zero; dword requests with DATA_W = 32 are also misaligned.
REQ-022 Misaligned accepted request: no entry is written; st_ades is high for exactly the following cycle.
REQ-023 Replication:
- byte: st_data[7:0] repeated DATA_W/8 times;
- half: st_data[15:0] repeated DATA_W/16 times;
- word: st_data[31:0] repeated DATA_W/32 times;
- dword: st_data unchanged.
REQ-024 Strobe: (2^st_size) ones, shifted left by st_addr[log2(DATA_W/8)-1:0].
REQ-025 Formatting (REQ-023, REQ-024) is computed at enqueue; entries store the aligned address, formatted data and strobe.
REQ-026 Ordering: the buffer is a FIFO; the entry at the head drives mem_req, mem_addr, mem_wdata and mem_wstrb.
REQ-027 Latency: a store accepted in cycle N into an empty buffer raises mem_req in cycle N+1; there is no combinational path from st_* to mem_*.
REQ-028 Pop: the head pops when mem_req and mem_ack are both high.
REQ-029 Head stability: while mem_req is high and mem_ack is low, all mem_* outputs hold stable.
REQ-030 Simultaneous enqueue and pop in one cycle leaves the count unchanged and the order preserved.
REQ-031 Full and empty: with DEPTH entries, st_ready is low; a pop in that cycle raises st_ready the next cycle, with no same-cycle bypass. When empty, mem_req is low, and mem_ack is ignored.
REQ-032 Pointers wrap modulo DEPTH; the count ranges 0..DEPTH.
REQ-033 ld_hit (combinational) is high when any valid entry's aligned address equals ld_addr aligned down to DATA_W/8 bytes.
REQ-034 empty equals (count == 0).

Reset
REQ-035 While resetn is low: pointers and count are 0; st_ready = 1, st_ades = 0, mem_req = 0, empty = 1, ld_hit = 0.
REQ-036 Reset asserted mid-operation discards all entries, including a head awaiting mem_ack; mem_wdata and mem_wstrb read 0 while empty.

Structure
REQ-037 The size encodings (SZ_B, SZ_H, SZ_W, SZ_D) live in shared package store_pkg.
REQ-038 Replication, strobe generation and the misalignment check form a combinational sub-module, store_fmt, parameterised by DATA_W; FIFO storage and control stay in store_align_buffer.

Verification
REQ-039 DATA_W = 32, byte store, addr 0x1003, data 0xAB: next cycle mem_addr = 0x1000, mem_wdata = 0xABABABAB, mem_wstrb = 0b1000.
REQ-040 DATA_W = 64, half store, addr 0x2006, data 0x1234: mem_addr = 0x2000, mem_wdata = 0x1234123412341234, mem_wstrb = 0xC0.
REQ-041 Word store to addr 0x1002: st_ades is high for exactly one cycle, no entry is written, empty stays 1.
REQ-042 DEPTH = 4, mem_ack held low, 5 back-to-back stores: the 5th is refused because st_ready is low. Then one mem_ack pulse: exactly one pop, st_ready rises the next cycle, and drain order matches issue order.
REQ-043 Store buffered at 0x3004, ld_addr = 0x3006 -> ld_hit = 1; ld_addr = 0x3008 -> ld_hit = 0.
REQ-044 resetn pulsed low with 3 entries and mem_req high: immediately mem_req = 0 and empty = 1, and after release no stale entry reappears.
